fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, one-outstanding req/ack memory port,
// and a small {pc, word} FIFO feeding the decoder, with redirect/flush support.
module fetch_unit #(
  parameter int             n        = 32,
  parameter logic [n-1:0]   RESET_PC = '0,
  parameter int             DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  output logic [n-1:0] instr,
  output logic [n-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         PCSel,
  input  logic [n-1:0] target
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [n-1:0]  NOP  = n'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [n-1:0]  fpc_reg, fpc_next;
  logic [n-1:0]  hold_reg, hold_next;
  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;

  logic [n-1:0]  pc_mem   [DEPTH];
  logic [n-1:0]  word_mem [DEPTH];

  logic          push, pop;
  logic [AW:0]   post_count;
  logic [n-1:0]  target_al;

  assign target_al = {target[n-1:2], 2'b00};
  assign pop       = (count_reg != '0) && instr_ready && !PCSel;
  // Only used on the push path, where BUSY guarantees count_reg < DEPTH.
  assign post_count = count_reg + (AW+1)'(1) - (AW+1)'(pop);

  always_comb begin
    state_next = state_reg;
    fpc_next   = fpc_reg;
    hold_next  = hold_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (PCSel)                 fpc_next   = target_al;
        else if (count_reg < FULL) state_next = BUSY;
      end
      BUSY: begin
        if (PCSel) begin
          fpc_next = target_al;
          if (imem_ack) begin
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
            hold_next  = fpc_reg;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fpc_next   = fpc_reg + n'(4);
          state_next = (post_count < FULL) ? BUSY : IDLE;
        end
      end
      DRAIN: begin
        // The aborted address stays on imem_addr; fpc already holds the target.
        if (PCSel)    fpc_next   = target_al;
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (PCSel) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      fpc_reg    <= RESET_PC;
      hold_reg   <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      fpc_reg    <= fpc_next;
      hold_reg   <= hold_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= fpc_reg;
      word_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

  assign imem_req    = (state_reg != IDLE);
  assign imem_addr   = (state_reg == DRAIN) ? hold_reg : fpc_reg;
  assign instr_valid = (count_reg != '0);
  assign instr       = instr_valid ? word_mem[rd_ptr_reg] : NOP;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench is the instruction memory and the
// decoder, and checks the delivered stream against an in-order PC model.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, instr_valid, instr_ready, PCSel;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, target;

  fetch_unit #(.n(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCSel(PCSel), .target(target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs
  int lat_min, lat_max, ready_pct, sel_pct, force_sel_cyc;
  logic [31:0] force_tgt;
  bit chk_tput;

  // Reference model state
  int          cyc, occ, acks;
  bit          mem_busy, mem_stale, prev_sel, saw_wrap;
  int          mem_wait;
  logic [31:0] mem_addr, exp_pc, exp_fetch;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_init();
    cyc = 0; occ = 0; acks = 0;
    mem_busy = 0; mem_stale = 0; prev_sel = 0; saw_wrap = 0; mem_wait = 0;
    mem_addr = '0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 0; imem_rdata = '0; instr_ready = 0; PCSel = 0; target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 0);
    check("rst_valid", {31'b0, instr_valid}, 0);
    check("rst_instr", instr, NOP);
    check("rst_pc", instr_pc, 0);
    check("rst_addr", imem_addr, RESET_PC);
    rst = 1'b0;
    model_init();
  endtask

  task automatic cycle();
    logic ack, sel, rdy, pop;
    logic [31:0] tgt;
    int r;
    @(negedge clk);
    cyc++;
    if (cyc == 1) check("req_rise", {31'b0, imem_req}, 1);
    if (chk_tput && cyc >= 2) check("throughput", {31'b0, instr_valid}, 1);
    if (prev_sel) check("flush_valid", {31'b0, instr_valid}, 0);
    check("valid", {31'b0, instr_valid}, {31'b0, occ > 0});
    if (instr_valid) begin
      check("head_pc", instr_pc, exp_pc);
      check("head_word", instr, memf(exp_pc));
    end else begin
      check("empty_instr", instr, NOP);
      check("empty_pc", instr_pc, 0);
    end
    if (mem_busy) begin
      check("req_hold", {31'b0, imem_req}, 1);
      check("addr_hold", imem_addr, mem_addr);
    end else if (imem_req) begin
      check("req_not_full", {31'b0, occ < DEPTH}, 1);
      check("addr_align", {30'b0, imem_addr[1:0]}, 0);
      mem_busy  = 1;
      mem_stale = 0;
      mem_addr  = imem_addr;
      mem_wait  = $urandom_range(lat_max, lat_min);
    end
    ack = mem_busy && (mem_wait == 0);
    if (mem_busy && !ack) mem_wait--;
    imem_ack   = ack;
    imem_rdata = ack ? memf(mem_addr) : $urandom;
    if (cyc == force_sel_cyc) begin
      sel = 1; tgt = force_tgt;
    end else begin
      sel = ($urandom_range(99, 0) < sel_pct);
      r = $urandom_range(3, 0);
      tgt = (r == 0) ? 32'hFFFF_FFFC : (r == 1) ? 32'hFFFF_FFFE : $urandom;
    end
    rdy = ($urandom_range(99, 0) < ready_pct);
    PCSel = sel; target = tgt; instr_ready = rdy;
    pop = instr_valid && rdy && !sel;
    @(posedge clk);
    if (ack) begin
      mem_busy = 0;
      if (!mem_stale && !sel) begin
        check("fetch_addr", mem_addr, exp_fetch);
        exp_fetch += 4;
        occ++;
        acks++;
      end
    end
    if (pop) begin
      if (exp_pc == 32'hFFFF_FFFC) saw_wrap = 1;
      occ--;
      exp_pc += 4;
    end
    if (sel) begin
      occ = 0;
      exp_pc    = {tgt[31:2], 2'b00};
      exp_fetch = {tgt[31:2], 2'b00};
      if (mem_busy) mem_stale = 1;
    end
    prev_sel = sel;
  endtask

  task automatic setup(input int lmin, input int lmax, input int rp, input int sp,
                       input int fcyc, input logic [31:0] ftgt, input bit tput);
    lat_min = lmin; lat_max = lmax; ready_pct = rp; sel_pct = sp;
    force_sel_cyc = fcyc; force_tgt = ftgt; chk_tput = tput;
  endtask

  initial begin
    model_init();
    // Zero-wait memory, decoder always ready: back-to-back stream from 0.
    setup(0, 0, 100, 0, -1, 0, 1);
    do_reset();
    repeat (12) cycle();

    // Decoder stalled: exactly DEPTH fetches, then the port goes quiet.
    setup(0, 0, 0, 0, -1, 0, 0);
    do_reset();
    repeat (10) cycle();
    check("stall_acks", acks, DEPTH);
    @(negedge clk);
    check("stall_req", {31'b0, imem_req}, 0);
    ready_pct = 100;
    repeat (6) cycle();

    // Slow memory with a redirect to 0x102 during the wait.
    setup(3, 3, 100, 0, 2, 32'h0000_0102, 0);
    do_reset();
    repeat (16) cycle();
    check("redir_delivered", {31'b0, exp_pc > 32'h100}, 1);

    // Redirect to the top of the address space wraps to zero.
    setup(0, 0, 100, 0, 3, 32'hFFFF_FFFC, 0);
    do_reset();
    repeat (10) cycle();
    check("wrap_seen", {31'b0, saw_wrap}, 1);

    // Randomized traffic.
    setup(0, 3, 60, 8, -1, 0, 0);
    do_reset();
    repeat (3000) cycle();

    // Asynchronous reset with a request outstanding and one word buffered.
    setup(0, 0, 0, 0, -1, 0, 0);
    do_reset();
    cycle();
    @(negedge clk);
    check("pre_rst_req", {31'b0, imem_req}, 1);
    check("pre_rst_valid", {31'b0, instr_valid}, 1);
    #2 rst = 1'b1;
    #1;
    check("async_req", {31'b0, imem_req}, 0);
    check("async_valid", {31'b0, instr_valid}, 0);
    check("async_addr", imem_addr, RESET_PC);
    check("async_instr", instr, NOP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
